// File: rtl/mux_round_robin_arbiter.sv
// Round-robin arbiter that shares one 4:1 mux among four requesters.
// The grant, its binary mux select and the valid flag are all registered
// together, so the mux select never glitches off the raw request lines.
module mux_round_robin_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic       grant_valid,
    output logic [1:0] selector_bits,
    output logic [7:0] hold_count
);

    localparam logic [7:0] MAX_H = 8'(MAX_HOLD);

    typedef enum logic {IDLE, GRANT} state_e;

    state_e     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] sel_q, sel_d;
    logic       gv_q, gv_d;
    logic [7:0] hold_q, hold_d;

    // Candidates for a new grant never include the current grantee; in IDLE
    // grant_q is zero so this is simply req.
    logic [3:0] mask;
    logic       pick_any;
    logic [1:0] pick_idx;
    logic       own_req;
    logic       others_req;

    assign mask       = req & ~grant_q;
    assign own_req    = |(req & grant_q);
    assign others_req = |mask;

    // Rotating priority search: first set mask bit starting at the pointer.
    always_comb begin
        pick_any = 1'b0;
        pick_idx = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            if (mask[ptr_q + 2'(k)]) begin
                pick_any = 1'b1;
                pick_idx = ptr_q + 2'(k);
            end
        end
    end

    // Next-state: keep, hand over (release/preempt) or fall back to idle.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        gv_d    = gv_q;
        hold_d  = hold_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = GRANT;
                    grant_d = 4'b0001 << pick_idx;
                    sel_d   = pick_idx;
                    gv_d    = 1'b1;
                    hold_d  = 8'd1;
                    ptr_d   = pick_idx + 2'd1;
                end
            end
            GRANT: begin
                if (own_req && (hold_q < MAX_H || !others_req)) begin
                    // Tenure continues; the count saturates at the limit.
                    if (hold_q < MAX_H) hold_d = hold_q + 8'd1;
                end else if (pick_any) begin
                    // Release or preemption with someone waiting: hand over
                    // on this edge without an idle cycle.
                    grant_d = 4'b0001 << pick_idx;
                    sel_d   = pick_idx;
                    hold_d  = 8'd1;
                    ptr_d   = pick_idx + 2'd1;
                end else begin
                    state_d = IDLE;
                    grant_d = 4'b0000;
                    sel_d   = 2'b00;
                    gv_d    = 1'b0;
                    hold_d  = 8'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset clears everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            grant_q <= 4'b0000;
            sel_q   <= 2'b00;
            gv_q    <= 1'b0;
            hold_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            gv_q    <= gv_d;
            hold_q  <= hold_d;
        end
    end

    assign grant         = grant_q;
    assign grant_valid   = gv_q;
    assign selector_bits = sel_q;
    assign hold_count    = hold_q;

endmodule

// File: doc/mux_round_robin_arbiter.md
# mux_round_robin_arbiter

Round-robin arbiter that shares one FourToOneMux datapath among four requesters. It drives the mux `selector_bits` from a registered one-hot grant, so the mux always forwards the granted requester's line. Each requester keeps its grant for as long as it holds its request, up to a configurable hold limit. When the limit is reached and another requester is waiting, the grant rotates to the next requester.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive granted cycles while another requester is waiting; legal range 1..255.
- `clk`  input  1  single system clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `req`  input  4  per-requester request, level; bit i = requester i; held high while the requester wants the mux.
- `grant`  output  4  registered one-hot grant; all-zero when idle.
- `grant_valid`  output  1  high when `grant` is non-zero.
- `selector_bits`  output  2  binary encoding of `grant`; connects directly to the mux `selector_bits`; 2'b00 when idle.
- `hold_count`  output  8  cycles the current grantee has held the grant, including the current cycle; 0 when idle.

## Operation
- Reset values: `grant`=4'b0000, `grant_valid`=0, `selector_bits`=2'b00, `hold_count`=0.
- Reset values, internal: rotation pointer=0, state IDLE.
- Reset is asynchronous. Asserting it mid-grant clears all state immediately, without waiting for a clock edge.
- States:
  - IDLE: no grant.
  - GRANT: exactly one `grant` bit set.
- Selection: search `req` starting at the pointer index, wrapping modulo 4; pick the first set bit.
- On issuing a grant to index i, the pointer becomes (i+1) mod 4. Priority order at reset is 0,1,2,3.
- IDLE -> GRANT: at an edge where `req`≠0. Grant the selected index and load `hold_count`=1.
- IDLE -> IDLE: at an edge where `req`=0.
- GRANT, grantee's `req` bit high, and either `hold_count`<`MAX_HOLD` or no other `req` bit set: keep the grant.
  - `hold_count` increments, saturating at `MAX_HOLD`.
- GRANT, grantee's `req` bit high, `hold_count`=`MAX_HOLD`, and another `req` bit set (preemption):
  - Grant the next selected index among the other requesters, same edge, no idle cycle.
  - Load `hold_count`=1.
- GRANT, grantee's `req` bit low (release):
  - If another `req` bit is set, grant the selected index, same edge, no idle cycle, and load `hold_count`=1.
  - Otherwise go to IDLE; `grant`=0, `hold_count`=0.
- Selection on release and preemption excludes the current grantee.
- `selector_bits` and `grant_valid` are registered alongside `grant`. They are never decoded combinationally from `req`.
- Invariant: `grant` is always one-hot or zero.
- Invariant: `selector_bits` always encodes `grant`.

## Timing
- Request to grant: a request sampled at edge N while IDLE produces a grant visible after edge N; latency is 1 cycle.
- Release to handover: a grantee that drops `req` before edge N loses the grant at edge N.
  - The next requester's grant is visible after that same edge N.
- Contended tenure: with other requesters waiting, a grantee holds the grant for exactly `MAX_HOLD` cycles.
- Uncontended tenure: a lone requester holds the grant indefinitely; `hold_count` stays at `MAX_HOLD`.
- When a new requester appears while `hold_count`=`MAX_HOLD`, it receives the grant at the next edge.
- Simultaneous events: release and preemption at the same edge are treated as release, so the result is identical.
- Requests arriving at the same edge as a handover take part in that edge's selection.
- Mux path: the mux output reflects the new grantee's input line in the same cycle the new grant becomes visible.

## Test plan
- Reset and idle:
  - Stimulus: assert `reset`, then release it with `req`=4'b0000 for 5 cycles.
  - Required: `grant`=0, `selector_bits`=2'b00, `grant_valid`=0, `hold_count`=0 throughout.
- Single requester:
  - Stimulus: `req`=4'b0100 sampled at edge 1.
  - Required: after edge 1, `grant`=4'b0100, `selector_bits`=2'b10, `hold_count`=1.
  - Stimulus: drop `req` before edge 4.
  - Required: after edge 4, IDLE with `grant`=0.
- Full contention, `MAX_HOLD`=4:
  - Stimulus: `req`=4'b1111 held constant.
  - Required grant sequence: 0001 ×4 cycles, 0010 ×4, 0100 ×4, 1000 ×4, then 0001 again.
  - Required: `hold_count` steps 1,2,3,4 within each tenure.
- Back-to-back release:
  - Stimulus: requester 0 granted with `req`=4'b1011, then `req` changes to 4'b1010.
  - Required: the next cycle shows `grant`=4'b0010 with no idle cycle, followed later by 4'b1000 in rotation order.
- Lone requester past the hold limit, `MAX_HOLD`=4:
  - Stimulus: `req`=4'b0001 for 10 cycles.
  - Required: grant is kept and `hold_count` saturates at 4.
  - Stimulus: raise `req[3]`.
  - Required: `grant`=4'b1000 after the next edge.
- Asynchronous reset mid-grant:
  - Stimulus: assert `reset` between edges while `grant`=4'b0100.
  - Required: outputs go to 0 before the next edge.
  - Stimulus: after release, apply `req`=4'b1111.
  - Required: grant goes to requester 0 first.
